keccak_feeder: RTL and testbench

KECCAK_FEEDER -- requirements
Module: keccak_feeder

---
 rtl/keccak_feeder_if.sv | 25 ++
 rtl/keccak_feeder.sv | 113 +++++++++++
 tb/tb_keccak_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_feeder_if.sv
// Byte-stream and hasher-side signals of the Keccak feeder.
// slave is the feeder's view; master is the view of the byte source and hasher.
interface keccak_feeder_if;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [31:0] in;
   logic        in_ready;
   logic        is_last;
   logic [1:0]  byte_num;
   logic        buffer_full;
   logic        out_ready;
   logic        msg_done;

   modport slave (
      input  s_data, s_valid, s_last, buffer_full, out_ready,
      output s_ready, in, in_ready, is_last, byte_num, msg_done
   );

   modport master (
      output s_data, s_valid, s_last, buffer_full, out_ready,
      input  s_ready, in, in_ready, is_last, byte_num, msg_done
   );
endinterface

// File: rtl/keccak_feeder.sv
// Packs a byte stream big-endian into 32-bit words for a Keccak hasher and
// marks the final word with its valid byte count.
module keccak_feeder (
   input logic             clk,
   input logic             reset,
   keccak_feeder_if.slave  bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ACC_W  = 24;

   typedef enum logic [1:0] {FILL, TERM, WAIT} state_t;

   state_t              r_state;
   logic [1:0]          r_count;
   logic [ACC_W-1:0]    r_acc;
   logic [WORD_W-1:0]   r_in;
   logic                r_in_ready;
   logic                r_is_last;
   logic [1:0]          r_byte_num;
   logic                r_msg_done;
   logic                r_s_ready;

   logic                w_xfer;
   logic                w_drain;
   logic [WORD_W-1:0]   w_word;

   assign w_xfer  = bus.s_valid & r_s_ready;
   assign w_drain = r_in_ready & ~bus.buffer_full;

   // Accumulated bytes with the incoming byte inserted at slot r_count.
   always_comb begin
      w_word = '0;
      unique case (r_count)
         2'd0:    w_word = {bus.s_data, 24'h0};
         2'd1:    w_word = {r_acc[23:16], bus.s_data, 16'h0};
         2'd2:    w_word = {r_acc[23:8], bus.s_data, 8'h0};
         default: w_word = {r_acc, bus.s_data};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= FILL;
         r_count    <= 2'd0;
         r_acc      <= '0;
         r_in       <= '0;
         r_in_ready <= 1'b0;
         r_is_last  <= 1'b0;
         r_byte_num <= 2'd0;
         r_msg_done <= 1'b0;
         r_s_ready  <= 1'b1;
      end else begin
         r_msg_done <= 1'b0;
         if (w_drain) r_in_ready <= 1'b0;

         unique case (r_state)
            FILL: begin
               if (w_xfer) begin
                  if (r_count == 2'd3 || bus.s_last) begin
                     r_in       <= w_word;
                     r_in_ready <= 1'b1;
                     r_s_ready  <= 1'b0;
                     r_count    <= 2'd0;
                     r_acc      <= '0;
                     if (r_count == 2'd3) begin
                        // Full word; an exact multiple of 4 still owes an empty final word.
                        r_is_last  <= 1'b0;
                        r_byte_num <= 2'd0;
                        r_state    <= bus.s_last ? TERM : FILL;
                     end else begin
                        r_is_last  <= 1'b1;
                        r_byte_num <= r_count + 2'd1;
                        r_state    <= WAIT;
                     end
                  end else begin
                     r_acc   <= w_word[31:8];
                     r_count <= r_count + 2'd1;
                  end
               end else begin
                  r_s_ready <= ~r_in_ready | w_drain;
               end
            end
            TERM: begin
               if (!r_in_ready || w_drain) begin
                  r_in       <= '0;
                  r_in_ready <= 1'b1;
                  r_is_last  <= 1'b1;
                  r_byte_num <= 2'd0;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               // Digest is only honoured once the final word has left pend.
               if (!r_in_ready && bus.out_ready) begin
                  r_msg_done <= 1'b1;
                  r_state    <= FILL;
                  r_count    <= 2'd0;
                  r_acc      <= '0;
                  r_s_ready  <= 1'b1;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign bus.s_ready  = r_s_ready;
   assign bus.in       = r_in;
   assign bus.in_ready = r_in_ready;
   assign bus.is_last  = r_is_last;
   assign bus.byte_num = r_byte_num;
   assign bus.msg_done = r_msg_done;
endmodule

// File: tb/tb_keccak_feeder.sv
// Directed bench for keccak_feeder: message packing, termination words,
// hasher stall, mid-message reset and msg_done timing.
module tb_keccak_feeder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   keccak_feeder_if bus();

   keccak_feeder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   bit last_seen = 1'b0;

   logic [31:0] mon_w[$];
   logic        mon_l[$];
   logic [1:0]  mon_b[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Record words at the negedge before the edge that consumes them.
   always @(negedge clk) begin
      if (!reset && bus.in_ready === 1'b1 && bus.buffer_full === 1'b0) begin
         mon_w.push_back(bus.in);
         mon_l.push_back(bus.is_last);
         mon_b.push_back(bus.byte_num);
         if (bus.is_last) last_seen = 1'b1;
      end
      if (bus.msg_done === 1'b1) done_cnt++;
   end

   task automatic clear_mon();
      mon_w.delete();
      mon_l.delete();
      mon_b.delete();
      last_seen = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      bit ok = 1'b0;
      bus.s_data  = b;
      bus.s_last  = last;
      bus.s_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 32'(0), 32'(1));
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic send_msg(input string m);
      for (int i = 0; i < m.len(); i++) send_byte(m[i], i == m.len() - 1);
   endtask

   task automatic wait_last();
      for (int i = 0; i < 500; i++) begin
         if (last_seen) break;
         @(posedge clk); #1;
      end
      if (!last_seen) check("last_timeout", 32'(0), 32'(1));
   endtask

   // Expected word stream of a message, compared with what the monitor saw.
   task automatic check_msg(input string tag, input string m);
      logic [31:0] ew[$];
      logic [31:0] w;
      int n;
      n = m.len();
      w = '0;
      for (int i = 0; i < n; i++) begin
         w[31 - 8*(i%4) -: 8] = m[i];
         if (i % 4 == 3 || i == n - 1) begin
            ew.push_back(w);
            w = '0;
         end
      end
      if (n % 4 == 0) ew.push_back(32'h0);
      check({tag, "_count"}, 32'(mon_w.size()), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < mon_w.size(); i++) begin
         check($sformatf("%s_w%0d", tag, i), mon_w[i], ew[i]);
         check($sformatf("%s_last%0d", tag, i), 32'(mon_l[i]), 32'(i == ew.size() - 1));
         check($sformatf("%s_bn%0d", tag, i), 32'(mon_b[i]),
               (i == ew.size() - 1) ? 32'(n % 4) : 32'(0));
      end
   endtask

   task automatic finish_msg(input string tag, input int exp_done);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_done_early"}, 32'(bus.msg_done), 32'(0));
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.msg_done), 32'(1));
      check({tag, "_sready_after"}, 32'(bus.s_ready), 32'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_done_clear"}, 32'(bus.msg_done), 32'(0));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
      @(posedge clk); #1;
   endtask

   task automatic stall_quic();
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready && bus.in == 32'h54686520) begin found = 1'b1; break; end
      end
      if (!found) check("stall_the_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
      bus.buffer_full = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready && bus.in == 32'h71756963) begin found = 1'b1; break; end
      end
      if (!found) check("stall_quic_timeout", 32'(0), 32'(1));
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall_in%0d", i), bus.in, 32'h71756963);
         check($sformatf("stall_rdy%0d", i), 32'(bus.in_ready), 32'(1));
         check($sformatf("stall_sready%0d", i), 32'(bus.s_ready), 32'(0));
         @(posedge clk); #1;
         if (i == 4) bus.buffer_full = 1'b0;
         else @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_data      = 8'h0;
      bus.s_valid     = 1'b0;
      bus.s_last      = 1'b0;
      bus.buffer_full = 1'b0;
      bus.out_ready   = 1'b0;
      reset           = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'(0));
      check("rst_in", bus.in, 32'h0);
      check("rst_is_last", 32'(bus.is_last), 32'(0));
      check("rst_byte_num", 32'(bus.byte_num), 32'(0));
      check("rst_msg_done", 32'(bus.msg_done), 32'(0));
      check("rst_s_ready", 32'(bus.s_ready), 32'(1));
      @(posedge clk); #1;
      reset = 1'b0;

      // 13 bytes: partial final word with one byte
      clear_mon();
      send_msg("Hello, world!");
      wait_last();
      check_msg("hello13", "Hello, world!");
      if (mon_w.size() == 4) begin
         check("hello13_w0_const", mon_w[0], 32'h48656C6C);
         check("hello13_w3_const", mon_w[3], 32'h21000000);
         check("hello13_bn3_const", 32'(mon_b[3]), 32'(1));
      end else check("hello13_size_const", 32'(mon_w.size()), 32'(4));
      finish_msg("hello13", 1);

      // 12 bytes: s_last on a fourth byte produces an empty final word
      clear_mon();
      send_msg("Hello, world");
      wait_last();
      check_msg("hello12", "Hello, world");
      if (mon_w.size() == 4) begin
         check("hello12_w2_const", mon_w[2], 32'h6F726C64);
         check("hello12_w3_const", mon_w[3], 32'h0);
         check("hello12_l2_const", 32'(mon_l[2]), 32'(0));
      end else check("hello12_size_const", 32'(mon_w.size()), 32'(4));
      finish_msg("hello12", 2);

      // 43 bytes: three-byte final word
      clear_mon();
      send_msg("The quick brown fox jumps over the lazy dog");
      wait_last();
      check_msg("fox", "The quick brown fox jumps over the lazy dog");
      if (mon_w.size() == 11) begin
         check("fox_w0_const", mon_w[0], 32'h54686520);
         check("fox_w10_const", mon_w[10], 32'h646F6700);
         check("fox_bn10_const", 32'(mon_b[10]), 32'(3));
      end else check("fox_size_const", 32'(mon_w.size()), 32'(11));
      finish_msg("fox", 3);

      // hasher stalls for five cycles on "quic"
      clear_mon();
      fork
         send_msg("The quick brown");
         stall_quic();
      join
      @(posedge clk); #1;
      wait_last();
      check_msg("stall", "The quick brown");
      finish_msg("stall", 4);

      // reset after six bytes discards the partial message
      clear_mon();
      for (int i = 0; i < 6; i++) send_byte(8'h41 + 8'(i), 1'b0);
      @(posedge clk); #1;
      check("mid_pre_count", 32'(mon_w.size()), 32'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'(0));
      check("mid_rst_s_ready", 32'(bus.s_ready), 32'(1));
      @(posedge clk); #1;
      clear_mon();
      send_msg("1234567890");
      wait_last();
      check_msg("mid", "1234567890");
      if (mon_w.size() == 3) begin
         check("mid_w0_const", mon_w[0], 32'h31323334);
         check("mid_w1_const", mon_w[1], 32'h35363738);
         check("mid_w2_const", mon_w[2], 32'h39300000);
         check("mid_bn2_const", 32'(mon_b[2]), 32'(2));
      end else check("mid_size_const", 32'(mon_w.size()), 32'(3));
      finish_msg("mid", 5);

      // out_ready while the final word is stalled is ignored
      clear_mon();
      bus.buffer_full = 1'b1;
      send_msg("xyz");
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("early_done%0d", i), 32'(bus.msg_done), 32'(0));
         check($sformatf("early_rdy%0d", i), 32'(bus.in_ready), 32'(1));
      end
      @(posedge clk); #1;
      bus.out_ready   = 1'b0;
      bus.buffer_full = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("early_done_after", 32'(bus.msg_done), 32'(0));
      check("early_in_ready_after", 32'(bus.in_ready), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("early_done_idle", 32'(bus.msg_done), 32'(0));
      @(posedge clk); #1;
      check_msg("early", "xyz");
      if (mon_w.size() == 1) check("early_w0_const", mon_w[0], 32'h78797A00);
      finish_msg("early", 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
